tc_sram: RTL and testbench
==========================

TC_SRAM -- requirements
Module: tc_sram

Interface
REQ-001 The block SHALL have parameter NumWords, default 1024, number of memory words.
REQ-002 The block SHALL have parameter DataWidth, default 128, bits per word.
REQ-003 The block SHALL have parameter ByteWidth, default 8, bits per byte-enable lane.
REQ-004 The block SHALL have parameter NumPorts, default 2, number of independent read/write ports.
REQ-005 The block SHALL have parameter Latency, default 1, read latency in cycles (0 = combinational).
REQ-006 The block SHALL have parameter SimInit, default "none", memory content after reset: "zeros", "ones", "random" or "none".
REQ-007 The block SHALL have parameter PrintSimCfg, default 0, print configuration at simulation start when 1.
REQ-008 Derived widths SHALL be AddrWidth = (NumWords > 1) ? clog2(NumWords) : 1 and BeWidth = ceil(DataWidth/ByteWidth).
REQ-009 clk_i  input  1  single clock, all state updates on rising edge.
REQ-010 rst_ni  input  1  reset, asynchronous, active-low.
REQ-011 req_i  input  [NumPorts]  per-port access request.
REQ-012 we_i  input  [NumPorts]  per-port write enable: 1 = write, 0 = read.
REQ-013 addr_i  input  [NumPorts][AddrWidth]  per-port word address.
REQ-014 wdata_i  input  [NumPorts][DataWidth]  per-port write data.
REQ-015 be_i  input  [NumPorts][BeWidth]  per-port byte enables; lane i covers bits [i*ByteWidth +: ByteWidth], clipped to DataWidth.
REQ-016 rdata_o  output  [NumPorts][DataWidth]  per-port read data.

Function
REQ-017 Write: a port with req_i=1 and we_i=1 SHALL update the lanes of mem[addr_i] whose be_i bit is 1 at the rising edge; other lanes are unchanged.
REQ-018 Read: a port with req_i=1 and we_i=0 SHALL present mem[addr_i] on its rdata_o exactly Latency cycles later; with Latency=0, rdata_o SHALL be combinational from addr_i.
REQ-019 Read data SHALL be sampled before writes of the same edge: a same-cycle read and write to one address returns the old content.
REQ-020 With Latency >= 1, rdata_o SHALL hold its last value when the port issues no read or issues a write; the read pipeline is a Latency-deep register chain per port.
REQ-021 Requests SHALL be accepted every cycle on every port with no back-pressure; pipelined reads on consecutive cycles are returned in order, one per cycle.
REQ-022 Simultaneous writes from several ports to one address SHALL resolve lane-wise with the highest-index port winning.
REQ-023 Addresses >= NumWords SHALL be ignored for writes and return all-zero for reads; simulation SHALL issue an error message.
REQ-024 be_i SHALL be ignored for reads.
REQ-025 When PrintSimCfg=1, simulation SHALL print all parameters once at time zero; an unknown SimInit value SHALL be a fatal simulation error.

Reset
REQ-026 While rst_ni=0, all rdata_o registers SHALL be 0 and writes SHALL be ignored.
REQ-027 On reset assertion, memory SHALL be loaded per SimInit: all-0, all-1, pseudo-random per word, or left unchanged for "none".
REQ-028 Reset asserted mid-read SHALL flush all pending read pipeline stages to 0.

Verification
REQ-029 Reset, SimInit="zeros", port0 read addr 5 -> port0 rdata_o = 0 one cycle later (Latency=1).
REQ-030 Port1 writes 0xA5..A5 to addr 3 with be all 1s; next cycle port0 reads addr 3 -> rdata_o[0] = 0xA5..A5 after 1 cycle.
REQ-031 Port0 writes 0xFF.. to addr 7 with be=...0001 over 0x00.. content -> a later read of addr 7 returns only byte 0 = 0xFF, rest 0.
REQ-032 Same cycle: port0 reads addr 9 (content 0x11), port1 writes 0x22 to addr 9 -> port0 gets 0x11; re-read gives 0x22.
REQ-033 Both ports write addr 2 (0x33 on port0, 0x44 on port1) -> read returns 0x44.
REQ-034 Back-to-back reads of addrs 0,1,2 with Latency=2 -> data appears on cycles 2,3,4 in order; rst_ni pulsed mid-stream -> rdata_o = 0 immediately.

Source files
------------

// File: rtl/tc_sram.sv
// Multi-port SRAM model with byte-lane writes and a configurable read pipeline.
// Read data is sampled before same-edge writes; the highest port wins lane-wise.
module tc_sram #(
    parameter int unsigned  NumWords    = 1024,
    parameter int unsigned  DataWidth   = 128,
    parameter int unsigned  ByteWidth   = 8,
    parameter int unsigned  NumPorts    = 2,
    parameter int unsigned  Latency     = 1,
    parameter               SimInit     = "none",
    parameter bit           PrintSimCfg = 1'b0,
    localparam int unsigned AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                req_i,
    input  logic [NumPorts-1:0]                we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
    output logic [NumPorts-1:0][DataWidth-1:0] rdata_o
);

    typedef logic [DataWidth-1:0]               word_t;
    typedef logic [NumPorts-1:0][DataWidth-1:0] bus_t;

    if (SimInit != "zeros" && SimInit != "ones" &&
        SimInit != "random" && SimInit != "none") begin : g_bad_init
        $fatal(1, "tc_sram: unknown SimInit value");
    end

    if (PrintSimCfg) begin : g_cfg
        $info("tc_sram: NumWords=%0d DataWidth=%0d ByteWidth=%0d NumPorts=%0d Latency=%0d SimInit=%s",
              NumWords, DataWidth, ByteWidth, NumPorts, Latency, SimInit);
    end

    // Deterministic per-word xorshift pattern, so "random" stays reproducible.
    function automatic word_t rand_word(input int unsigned idx);
        logic [31:0] s;
        word_t       w;
        s = idx * 32'h9e37_79b9 + 32'h7f4a_7c15;
        w = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            s ^= s << 13;
            s ^= s >> 17;
            s ^= s << 5;
            w[i] = s[31];
        end
        return w;
    endfunction

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return 32'(a) < NumWords;
    endfunction

    word_t mem_q [NumWords];
    word_t mem_d [NumWords];
    bus_t  rd_val;

    always_comb begin
        rd_val = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (in_range(addr_i[p])) begin
                rd_val[p] = mem_q[addr_i[p]];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (req_i[p] && we_i[p] && in_range(addr_i[p])) begin
                for (int b = 0; b < int'(DataWidth); b++) begin
                    if (be_i[p][b/ByteWidth]) begin
                        mem_d[addr_i[p]][b] = wdata_i[p][b];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < int'(NumWords); w++) begin
                if (SimInit == "zeros") begin
                    mem_q[w] <= '0;
                end else if (SimInit == "ones") begin
                    mem_q[w] <= '1;
                end else if (SimInit == "random") begin
                    mem_q[w] <= rand_word(w);
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    if (Latency == 0) begin : g_comb
        assign rdata_o = rd_val;
    end else begin : g_pipe
        bus_t                rdata_q;
        bus_t                rdata_d;
        bus_t                tail_data;
        logic [NumPorts-1:0] tail_vld;
        logic [NumPorts-1:0] rd_en;

        assign rd_en = req_i & ~we_i;

        if (Latency == 1) begin : g_one
            assign tail_vld  = rd_en;
            assign tail_data = rd_val;
        end else begin : g_chain
            localparam int unsigned Depth = Latency - 1;
            bus_t                pd_q [Depth];
            bus_t                pd_d [Depth];
            logic [NumPorts-1:0] pv_q [Depth];
            logic [NumPorts-1:0] pv_d [Depth];

            always_comb begin
                pd_d[0] = rd_val;
                pv_d[0] = rd_en;
                for (int k = 1; k < int'(Depth); k++) begin
                    pd_d[k] = pd_q[k-1];
                    pv_d[k] = pv_q[k-1];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < int'(Depth); k++) begin
                        pd_q[k] <= '0;
                        pv_q[k] <= '0;
                    end
                end else begin
                    pd_q <= pd_d;
                    pv_q <= pv_d;
                end
            end

            assign tail_vld  = pv_q[Depth-1];
            assign tail_data = pd_q[Depth-1];
        end

        // Output stage only moves when a read arrives, otherwise it holds.
        always_comb begin
            rdata_d = rdata_q;
            for (int p = 0; p < int'(NumPorts); p++) begin
                if (tail_vld[p]) begin
                    rdata_d[p] = tail_data[p];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_tc_sram.sv
// Randomized bench for tc_sram at latencies 0, 1 and 2 sharing one stimulus.
// A history of issued reads predicts each pipeline's output.
module tb_tc_sram;

    localparam int NW = 20;
    localparam int DW = 36;
    localparam int HL = 2048;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req;
    logic [1:0]           we;
    logic [1:0][4:0]      addr;
    logic [1:0][DW-1:0]   wdata;
    logic [1:0][4:0]      be;
    logic [1:0][DW-1:0]   r0;
    logic [1:0][DW-1:0]   r1;
    logic [1:0][DW-1:0]   r2;

    int n_cmp;
    int n_err;
    int n;
    int floor_e;

    logic [DW-1:0] mem [NW];
    bit            hv  [2][HL];
    logic [DW-1:0] hd  [2][HL];

    tc_sram #(
        .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(2),
        .Latency(0), .SimInit("zeros"), .PrintSimCfg(1'b0)
    ) u_l0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(r0)
    );

    tc_sram #(
        .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(2),
        .Latency(1), .SimInit("zeros"), .PrintSimCfg(1'b0)
    ) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(r1)
    );

    tc_sram #(
        .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(2),
        .Latency(2), .SimInit("zeros"), .PrintSimCfg(1'b0)
    ) u_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [4:0] a);
        if (int'(a) < NW) return mem[a];
        return '0;
    endfunction

    // Most recent read issued at least lat-1 edges before edge n, since reset.
    function automatic logic [DW-1:0] expect_out(input int lat, input int p);
        for (int e = n - lat + 1; e > floor_e; e--) begin
            if (hv[p][e]) return hd[p][e];
        end
        return '0;
    endfunction

    task automatic step();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (req[p] && !we[p])
                check($sformatf("l0_rd_p%0d", p), r0[p], model_read(addr[p]));
        end
        @(posedge clk);
        n++;
        if (n >= HL) begin
            $display("FAIL history got=%0d exp<%0d", n, HL);
            $fatal(1, "history overflow");
        end
        for (int p = 0; p < 2; p++) begin
            hv[p][n] = rst_n && req[p] && !we[p];
            hd[p][n] = model_read(addr[p]);
        end
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && we[p] && int'(addr[p]) < NW) begin
                    for (int b = 0; b < DW; b++) begin
                        if (be[p][b/8]) mem[addr[p]][b] = wdata[p][b];
                    end
                end
            end
        end
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("l1_p%0d_e%0d", p, n), r1[p], expect_out(1, p));
            check($sformatf("l2_p%0d_e%0d", p, n), r2[p], expect_out(2, p));
        end
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        for (int w = 0; w < NW; w++) mem[w] = '0;
        floor_e = n;
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rst_l1_p%0d", p), r1[p], '0);
            check($sformatf("rst_l2_p%0d", p), r2[p], '0);
        end
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    task automatic drive(input int p, input bit r, input bit w, input int a,
                         input logic [DW-1:0] d, input logic [4:0] b);
        req[p]   = r;
        we[p]    = w;
        addr[p]  = 5'(a);
        wdata[p] = d;
        be[p]    = b;
    endtask

    task automatic rand_in(input bit reads_only);
        for (int p = 0; p < 2; p++) begin
            req[p]   = ($urandom % 4) != 0;
            we[p]    = reads_only ? 1'b0 : 1'($urandom);
            if ($urandom % 5 == 0)      addr[p] = 5'($urandom_range(20, 31));
            else if ($urandom % 2 == 0) addr[p] = 5'($urandom_range(0, 3));
            else                        addr[p] = 5'($urandom_range(0, NW - 1));
            wdata[p] = {4'($urandom), $urandom};
            be[p]    = 5'($urandom);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        n       = 0;
        floor_e = 0;
        for (int w = 0; w < NW; w++) mem[w] = '0;
        rst_n = 1'b1;
        idle();
        addr  = '0;
        wdata = '0;
        be    = '0;
        #2;
        reset_assert();
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b0);
            step();
        end
        rst_n = 1'b1;
        idle();

        drive(0, 1, 0, 5, '0, '0);
        step();
        idle();
        drive(1, 1, 1, 3, {4'h5, {4{8'ha5}}}, 5'h1f);
        step();
        idle();
        drive(0, 1, 0, 3, '0, '0);
        step();
        check("wr_full_a5", r1[0], {4'h5, {4{8'ha5}}});

        idle();
        drive(0, 1, 1, 7, '1, 5'b00001);
        step();
        idle();
        drive(0, 1, 0, 7, '0, 5'h1f);
        step();
        check("wr_lane0", r1[0], 36'h0_0000_00ff);

        idle();
        drive(0, 1, 1, 9, 36'h11, 5'h1f);
        step();
        drive(0, 1, 0, 9, '0, '0);
        drive(1, 1, 1, 9, 36'h22, 5'h1f);
        step();
        check("rd_before_wr", r1[0], 36'h11);
        idle();
        drive(0, 1, 0, 9, '0, '0);
        step();
        check("reread", r1[0], 36'h22);

        drive(0, 1, 1, 2, 36'h33, 5'h1f);
        drive(1, 1, 1, 2, 36'h44, 5'h1f);
        step();
        idle();
        drive(0, 1, 0, 2, '0, '0);
        step();
        check("port_prio", r1[0], 36'h44);

        idle();
        drive(0, 1, 1, 30, '1, 5'h1f);
        step();
        drive(0, 1, 0, 30, '0, '0);
        step();
        check("oob_rd", r1[0], '0);

        idle();
        for (int a = 0; a < 3; a++) begin
            drive(0, 1, 0, a, '0, '0);
            step();
        end
        idle();
        step();
        check("b2b_l2_last", r2[0], 36'h44);
        step();

        for (int i = 0; i < 400; i++) begin
            rand_in(1'b0);
            step();
        end

        for (int i = 0; i < 6; i++) begin
            rand_in(1'b1);
            step();
        end
        reset_assert();
        for (int i = 0; i < 2; i++) begin
            rand_in(1'b0);
            step();
        end
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            rand_in(1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
